// File: rtl/gcn_coo_pkg.sv
// Shared types for the COO edge-stream decoder: the buffered edge record and the frame FSM states.
package gcn_coo_pkg;

  localparam int COO_IDX_W = 8;
  localparam int COO_ID_W  = 8;

  typedef struct packed {
    logic [COO_IDX_W-1:0] src;
    logic [COO_IDX_W-1:0] dst;
    logic [COO_ID_W-1:0]  id;
  } coo_edge_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } coo_state_t;

endpackage

// File: rtl/coo_skid_buffer.sv
// Two-entry in-order buffer; a push shows at the head one cycle later, and the head holds until ready.
// count_next lets the producer register its ready one cycle ahead; pushing while full is the producer's fault.
module coo_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       count,
  output logic [1:0]       count_next
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [1:0]       cnt;
  logic             pop;

  assign pop   = (cnt != 2'd0) && ready;
  assign valid = (cnt != 2'd0);
  assign data  = head;
  assign count = cnt;

  always_comb begin
    count_next = cnt;
    if (push && !pop && (cnt != 2'd2)) begin
      count_next = cnt + 2'd1;
    end else if (pop && !push) begin
      count_next = cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else begin
      cnt <= count_next;
      if (pop) begin
        if (cnt == 2'd2) begin
          head <= tail;
          if (push) begin
            tail <= push_data;
          end
        end else if (push) begin
          head <= push_data;
        end
      end else if (push) begin
        if (cnt == 2'd0) begin
          head <= push_data;
        end else if (cnt == 2'd1) begin
          tail <= push_data;
        end
      end
    end
  end

endmodule

// File: rtl/coo_edge_stream_decoder.sv
// Decodes a frame of COO (src,dst) beats into 0-based node index pairs, dropping bad edges and optionally self loops.
// Kept edges reach edge_valid one cycle after acceptance; coo_ready is registered and drops while the buffer is full.
import gcn_coo_pkg::*;

module coo_edge_stream_decoder #(
  parameter int COO_BW          = 3,
  parameter int FEATURE_WIDTH   = 3,
  parameter int NUM_NODES       = 6,
  parameter int NUM_EDGES       = 6,
  parameter int COO_ONE_INDEXED = 1,
  parameter int DROP_SELF_LOOPS = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  input  logic                             coo_valid,
  output logic                             coo_ready,
  input  logic [2*COO_BW-1:0]              coo_in,
  output logic                             edge_valid,
  input  logic                             edge_ready,
  output logic [FEATURE_WIDTH-1:0]         src_index,
  output logic [FEATURE_WIDTH-1:0]         dst_index,
  output logic [$clog2(NUM_EDGES+1)-1:0]   edge_id,
  output logic                             err_range,
  output logic [$clog2(NUM_EDGES+1)-1:0]   drop_count
);

  localparam int CNT_W = $clog2(NUM_EDGES + 1);

  coo_state_t        state;
  coo_state_t        state_next;
  logic [CNT_W-1:0]  in_cnt;
  logic              ready_q;

  logic [COO_BW-1:0] src_field;
  logic [COO_BW-1:0] dst_field;
  logic [COO_BW-1:0] src_conv;
  logic [COO_BW-1:0] dst_conv;
  logic              range_bad;
  logic              self_loop;
  logic              drop;
  logic              accept;
  logic              keep;
  logic              last_beat;

  logic [FEATURE_WIDTH-1:0] src_idx;
  logic [FEATURE_WIDTH-1:0] dst_idx;
  coo_edge_t         push_edge;
  coo_edge_t         head_edge;
  logic [1:0]        buf_count;
  logic [1:0]        buf_count_next;

  // Range is judged on the full-width converted value so truncation cannot hide a bad index.
  function automatic logic field_bad(input logic [COO_BW-1:0] field, input logic [COO_BW-1:0] conv);
    field_bad = ((COO_ONE_INDEXED != 0) && (field == '0)) || (32'(conv) >= 32'(NUM_NODES));
  endfunction

  assign {src_field, dst_field} = coo_in;
  assign src_conv  = (COO_ONE_INDEXED != 0) ? (src_field - COO_BW'(1)) : src_field;
  assign dst_conv  = (COO_ONE_INDEXED != 0) ? (dst_field - COO_BW'(1)) : dst_field;
  assign range_bad = field_bad(src_field, src_conv) || field_bad(dst_field, dst_conv);
  assign self_loop = (DROP_SELF_LOOPS != 0) && (src_conv == dst_conv);
  assign drop      = range_bad || self_loop;

  assign accept    = coo_valid && ready_q && (state == ST_RUN);
  assign keep      = accept && !drop;
  assign last_beat = accept && (in_cnt == CNT_W'(NUM_EDGES - 1));

  assign src_idx       = FEATURE_WIDTH'(src_conv);
  assign dst_idx       = FEATURE_WIDTH'(dst_conv);
  assign push_edge.src = COO_IDX_W'(src_idx);
  assign push_edge.dst = COO_IDX_W'(dst_idx);
  assign push_edge.id  = COO_ID_W'(in_cnt);

  coo_skid_buffer #(
    .WIDTH($bits(coo_edge_t))
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .push       (keep),
    .push_data  (push_edge),
    .ready      (edge_ready),
    .valid      (edge_valid),
    .data       (head_edge),
    .count      (buf_count),
    .count_next (buf_count_next)
  );

  assign src_index = FEATURE_WIDTH'(head_edge.src);
  assign dst_index = FEATURE_WIDTH'(head_edge.dst);
  assign edge_id   = CNT_W'(head_edge.id);
  assign coo_ready = ready_q;

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_beat) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (buf_count == 2'd0) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      ready_q    <= 1'b0;
      in_cnt     <= '0;
      drop_count <= '0;
      err_range  <= 1'b0;
    end else begin
      state <= state_next;
      // Ready for next cycle only if the buffer will still have a free slot after this cycle's push/pop.
      ready_q <= (state_next == ST_RUN) && (buf_count_next != 2'd2);
      if ((state == ST_IDLE) && start) begin
        in_cnt     <= '0;
        drop_count <= '0;
        err_range  <= 1'b0;
      end else if (accept) begin
        in_cnt <= in_cnt + CNT_W'(1);
        if (drop) begin
          drop_count <= drop_count + CNT_W'(1);
        end
        if (range_bad) begin
          err_range <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_coo_edge_stream_decoder.sv
// Directed bench: three decoder instances (defaults, self-loop drop, zero-indexed 8 nodes) share one input stream.
module tb_coo_edge_stream_decoder;

  typedef logic [5:0] beat6_t [6];
  typedef logic [8:0] ev6_t [6];

  logic       clk, reset, start, coo_valid, edge_ready;
  logic [5:0] coo_in;

  logic       a_busy, a_done, a_rdy, a_ev, a_err;
  logic [2:0] a_src, a_dst, a_id, a_drop;
  logic       b_busy, b_done, b_rdy, b_ev, b_err;
  logic [2:0] b_src, b_dst, b_id, b_drop;
  logic       c_busy, c_done, c_rdy, c_ev, c_err;
  logic [2:0] c_src, c_dst, c_id, c_drop;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_a = 0;
  int done_a = 0;
  int done_cyc_a = 0;
  int last_out_a = 0;
  logic [8:0] a_q[$];
  logic [8:0] b_q[$];
  logic [8:0] c_q[$];
  int ba, bb, bc, acc0;

  coo_edge_stream_decoder u_a (
    .clk(clk), .reset(reset), .start(start), .busy(a_busy), .done(a_done),
    .coo_valid(coo_valid), .coo_ready(a_rdy), .coo_in(coo_in),
    .edge_valid(a_ev), .edge_ready(edge_ready), .src_index(a_src), .dst_index(a_dst),
    .edge_id(a_id), .err_range(a_err), .drop_count(a_drop)
  );

  coo_edge_stream_decoder #(.DROP_SELF_LOOPS(1)) u_b (
    .clk(clk), .reset(reset), .start(start), .busy(b_busy), .done(b_done),
    .coo_valid(coo_valid), .coo_ready(b_rdy), .coo_in(coo_in),
    .edge_valid(b_ev), .edge_ready(edge_ready), .src_index(b_src), .dst_index(b_dst),
    .edge_id(b_id), .err_range(b_err), .drop_count(b_drop)
  );

  coo_edge_stream_decoder #(.COO_ONE_INDEXED(0), .NUM_NODES(8)) u_c (
    .clk(clk), .reset(reset), .start(start), .busy(c_busy), .done(c_done),
    .coo_valid(coo_valid), .coo_ready(c_rdy), .coo_in(coo_in),
    .edge_valid(c_ev), .edge_ready(edge_ready), .src_index(c_src), .dst_index(c_dst),
    .edge_id(c_id), .err_range(c_err), .drop_count(c_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change 1 time unit after posedge, so at negedge everything the next edge will see is settled.
  always @(negedge clk) begin
    cyc++;
    if (coo_valid && a_rdy) acc_a++;
    if (a_ev && edge_ready) begin
      a_q.push_back({a_src, a_dst, a_id});
      last_out_a = cyc;
    end
    if (b_ev && edge_ready) b_q.push_back({b_src, b_dst, b_id});
    if (c_ev && edge_ready) c_q.push_back({c_src, c_dst, c_id});
    if (a_done) begin
      done_a++;
      done_cyc_a = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] bt(input int s, input int d);
    bt = {3'(s), 3'(d)};
  endfunction

  function automatic logic [8:0] e(input int s, input int d, input int i);
    e = {3'(s), 3'(d), 3'(i)};
  endfunction

  task automatic check_edges(input string tag, input int which, input int base, input ev6_t exp, input int n);
    logic [8:0] got[$];
    case (which)
      0:       got = a_q;
      1:       got = b_q;
      default: got = c_q;
    endcase
    check({tag, "_count"}, got.size() - base, n);
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_e%0d", tag, k),
            (base + k < got.size()) ? 32'(got[base + k]) : 32'hFFFF_FFFF, 32'(exp[k]));
    end
  endtask

  task automatic snap();
    ba   = a_q.size();
    bb   = b_q.size();
    bc   = c_q.size();
    acc0 = acc_a;
  endtask

  task automatic run_frame(input beat6_t bts);
    int  i;
    int  guard;
    int  d0;
    logic rdy;
    d0 = done_a;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    i = 0;
    guard = 0;
    coo_valid = 1'b1;
    while (i < 6 && guard < 100) begin
      coo_in = bts[i];
      @(negedge clk);
      rdy = a_rdy;
      @(posedge clk); #1;
      if (rdy) i++;
      guard++;
    end
    coo_valid = 1'b0;
    check("feed_beats", i, 6);
    guard = 0;
    while (done_a == d0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_a - d0, 1);
  endtask

  initial begin
    beat6_t t1, t2, t3, t5;
    ev6_t   ea, ec;
    int     i, guard, d0;
    logic   rdy;

    reset = 1'b1; start = 1'b0; coo_valid = 1'b0; coo_in = '0; edge_ready = 1'b1;
    t1 = '{bt(1,2), bt(2,3), bt(3,1), bt(4,5), bt(5,6), bt(6,4)};
    t2 = '{bt(1,2), bt(0,3), bt(3,1), bt(7,2), bt(5,6), bt(6,4)};
    t3 = '{bt(1,2), bt(4,4), bt(2,3), bt(3,1), bt(5,6), bt(6,5)};
    t5 = '{bt(7,0), bt(1,2), bt(2,3), bt(3,4), bt(4,5), bt(5,6)};

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_ready", a_rdy, 0);
    check("rst_valid", a_ev, 0);
    check("rst_err", a_err, 0);
    check("rst_drop", a_drop, 0);
    check("rst_src", a_src, 0);
    check("rst_dst", a_dst, 0);
    check("rst_id", a_id, 0);
    #2 reset = 1'b0;

    // basic frame, continuous edge_ready
    snap();
    run_frame(t1);
    ea = '{e(0,1,0), e(1,2,1), e(2,0,2), e(3,4,3), e(4,5,4), e(5,3,5)};
    check_edges("t1_a", 0, ba, ea, 6);
    ec = '{e(1,2,0), e(2,3,1), e(3,1,2), e(4,5,3), e(5,6,4), e(6,4,5)};
    check_edges("t1_c", 2, bc, ec, 6);
    check("t1_drop", a_drop, 0);
    check("t1_err", a_err, 0);
    check("t1_done_lat", done_cyc_a - last_out_a, 1);
    check("t1_busy_after", a_busy, 0);

    // out-of-range fields on one-indexed instance; legal for zero-indexed 8-node instance
    snap();
    run_frame(t2);
    ea = '{e(0,1,0), e(2,0,2), e(4,5,4), e(5,3,5), 9'd0, 9'd0};
    check_edges("t2_a", 0, ba, ea, 4);
    check("t2_err", a_err, 1);
    check("t2_drop", a_drop, 2);
    ec = '{e(1,2,0), e(0,3,1), e(3,1,2), e(7,2,3), e(5,6,4), e(6,4,5)};
    check_edges("t2_c", 2, bc, ec, 6);
    check("t2_c_err", c_err, 0);
    check("t2_c_drop", c_drop, 0);

    // self loop: dropped only where enabled, never an error
    snap();
    run_frame(t3);
    ea = '{e(0,1,0), e(3,3,1), e(1,2,2), e(2,0,3), e(4,5,4), e(5,4,5)};
    check_edges("t3_a", 0, ba, ea, 6);
    check("t3_a_err", a_err, 0);
    check("t3_a_drop", a_drop, 0);
    ea = '{e(0,1,0), e(1,2,2), e(2,0,3), e(4,5,4), e(5,4,5), 9'd0};
    check_edges("t3_b", 1, bb, ea, 5);
    check("t3_b_err", b_err, 0);
    check("t3_b_drop", b_drop, 1);

    // output stall for 5 cycles mid-frame
    snap();
    ea = '{e(0,1,0), e(1,2,1), e(2,0,2), e(3,4,3), e(4,5,4), e(5,3,5)};
    fork
      run_frame(t1);
      begin
        int g;
        g = 0;
        while ((acc_a - acc0) < 2 && g < 100) begin
          @(posedge clk); #1;
          g++;
        end
        edge_ready = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("bp_ready_low", a_rdy, 0);
        check("bp_occupancy", (acc_a - acc0) - (a_q.size() - ba), 2);
        check("bp_valid_hold", a_ev, 1);
        check("bp_head", {a_src, a_dst, a_id}, ea[a_q.size() - ba]);
        @(posedge clk); #1 edge_ready = 1'b1;
      end
    join
    check_edges("t4_a", 0, ba, ea, 6);

    // zero-indexed max node passes on C, rejected on A
    snap();
    run_frame(t5);
    ec = '{e(7,0,0), e(1,2,1), e(2,3,2), e(3,4,3), e(4,5,4), e(5,6,5)};
    check_edges("t5_c", 2, bc, ec, 6);
    check("t5_c_err", c_err, 0);
    check("t5_c_drop", c_drop, 0);
    ea = '{e(0,1,1), e(1,2,2), e(2,3,3), e(3,4,4), e(4,5,5), 9'd0};
    check_edges("t5_a", 0, ba, ea, 5);
    check("t5_a_err", a_err, 1);
    check("t5_a_drop", a_drop, 1);

    // reset while two edges are buffered
    snap();
    d0 = done_a;
    edge_ready = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    i = 0;
    guard = 0;
    coo_valid = 1'b1;
    while (i < 2 && guard < 50) begin
      coo_in = t1[i];
      @(negedge clk);
      rdy = a_rdy;
      @(posedge clk); #1;
      if (rdy) i++;
      guard++;
    end
    coo_valid = 1'b0;
    check("rs_pre_busy", a_busy, 1);
    check("rs_pre_valid", a_ev, 1);
    check("rs_pre_ready", a_rdy, 0);
    #2 reset = 1'b1;
    @(negedge clk);
    check("rs_valid", a_ev, 0);
    check("rs_busy", a_busy, 0);
    check("rs_ready", a_rdy, 0);
    check("rs_dst", a_dst, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    edge_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rs_no_done", done_a - d0, 0);
    check("rs_no_out", a_q.size() - ba, 0);

    // clean frame after reset
    snap();
    run_frame(t1);
    ea = '{e(0,1,0), e(1,2,1), e(2,0,2), e(3,4,3), e(4,5,4), e(5,3,5)};
    check_edges("t7_a", 0, ba, ea, 6);
    check("t7_err", a_err, 0);
    check("t7_drop", a_drop, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coo_edge_stream_decoder.md
COO_EDGE_STREAM_DECODER -- requirements
Module: coo_edge_stream_decoder

Interface
REQ-001 SHALL have parameter COO_BW, default 3, meaning bit width of each COO field.
REQ-002 SHALL have parameter FEATURE_WIDTH, default 3, meaning bit width of output node indices.
REQ-003 SHALL have parameter NUM_NODES, default 6, meaning valid 0-indexed node range 0..NUM_NODES-1.
REQ-004 SHALL have parameter NUM_EDGES, default 6, meaning edges per frame, at least 1.
REQ-005 SHALL have parameter COO_ONE_INDEXED, default 1, meaning input fields are 1..NUM_NODES, not 0..NUM_NODES-1.
REQ-006 SHALL have parameter DROP_SELF_LOOPS, default 0, meaning edges with src==dst are discarded.
REQ-007 SHALL have ports: clk input 1, clock; reset input 1, asynchronous active-high reset.
REQ-008 SHALL have ports: start input 1, frame start pulse; busy output 1, frame in progress; done output 1, one-cycle frame-complete pulse.
REQ-009 SHALL have ports: coo_valid input 1; coo_ready output 1; coo_in input 2*COO_BW, packed {src field [2*COO_BW-1:COO_BW], dst field [COO_BW-1:0]}.
REQ-010 SHALL have ports: edge_valid output 1; edge_ready input 1; src_index output FEATURE_WIDTH; dst_index output FEATURE_WIDTH; edge_id output $clog2(NUM_EDGES+1), 0-based input position of the edge.
REQ-011 SHALL have ports: err_range output 1, sticky out-of-range flag; drop_count output $clog2(NUM_EDGES+1), edges discarded this frame.

Function
REQ-012 SHALL implement FSM IDLE, RUN, DRAIN; reset state IDLE.
REQ-013 IDLE: coo_ready=0, busy=0; start=1 -> RUN, clear input counter, drop_count, err_range.
REQ-014 RUN: busy=1; an input beat is accepted when coo_valid && coo_ready; input counter increments per accepted beat, dropped or not.
REQ-015 RUN -> DRAIN on acceptance of beat number NUM_EDGES-1; coo_ready=0 in DRAIN.
REQ-016 DRAIN -> IDLE when the output buffer is empty; done=1 for exactly that transition cycle.
REQ-017 start is ignored outside IDLE.
REQ-018 Index conversion: if COO_ONE_INDEXED, index = field - 1 computed in COO_BW bits, else index = field; result zero-extended or truncated to FEATURE_WIDTH.
REQ-019 Range error: a field is out of range if (COO_ONE_INDEXED and field==0) or converted index >= NUM_NODES, compared at full COO_BW width before truncation.
REQ-020 An out-of-range edge SHALL be dropped, set err_range, and increment drop_count.
REQ-021 When DROP_SELF_LOOPS=1, an in-range edge with src==dst SHALL be dropped and increment drop_count without setting err_range.
REQ-022 Kept edges SHALL pass through a 2-entry skid buffer; latency from input acceptance to edge_valid is 1 cycle when empty.
REQ-023 coo_ready SHALL be a registered signal: 1 in RUN when the buffer has at least one free entry after the current cycle; throughput 1 edge/cycle when edge_ready=1 continuously.
REQ-024 Edges SHALL leave in input order; edge_valid SHALL hold and outputs SHALL stay stable until edge_ready.
REQ-025 A dropped beat SHALL consume no buffer entry; simultaneous output pop and input push on a full buffer SHALL not be allowed (coo_ready=0 when full).

Reset
REQ-026 reset asserted SHALL asynchronously force state IDLE, buffer empty, edge_valid=0, coo_ready=0, busy=0, done=0, err_range=0, drop_count=0, counters=0, src_index=dst_index=edge_id=0.
REQ-027 Reset mid-frame SHALL discard buffered edges; no done pulse is produced.

Structure
REQ-028 Package gcn_coo_pkg SHALL hold the coo_edge_t struct {src, dst, id} and the FSM state enum.
REQ-029 The skid buffer SHALL be a sub-module coo_skid_buffer, parametrised by payload width.

Verification
REQ-030 Defaults, start, inputs {1,2},{2,3},{3,1},{4,5},{5,6},{6,4}, edge_ready=1 -> outputs (0,1),(1,2),(2,0),(3,4),(4,5),(5,3), ids 0..5, done 1 cycle after last output, drop_count=0.
REQ-031 Inputs include {0,3} and {7,2} -> both dropped, err_range=1, drop_count=2, remaining ids skip 0-based positions of dropped beats.
REQ-032 DROP_SELF_LOOPS=1, input {4,4} -> dropped, err_range=0, drop_count=1.
REQ-033 edge_ready=0 for 5 cycles mid-frame -> coo_ready falls after 2 kept edges, no loss or reorder after release.
REQ-034 reset asserted during RUN with 2 buffered edges -> next cycle edge_valid=0, busy=0, no done; new start runs a clean frame.
REQ-035 COO_ONE_INDEXED=0, NUM_NODES=8, COO_BW=3 -> {7,0} passes as (7,0), no error.
